fp32_result_fifo: RTL and testbench

//  Downstream stage of the posit-to-FP32 converter. Captures each converted word
//  (converter final_output qualified by output_valid), classifies it, and buffers it.

---
 rtl/posit_fp_pkg.sv | 31 +++
 rtl/fp32_result_fifo_classify.sv | 32 +++
 rtl/fp32_result_fifo.sv | 108 ++++++++++
 tb/tb_fp32_result_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/posit_fp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : posit_fp_pkg                                                  |
// | Purpose  : Shared FP32 field layout and result class codes for the       |
// |            posit-to-FP32 datapath.                                       |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
package posit_fp_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int MAN_LSB = 0;
   localparam int EXP_LSB = MAN_W;
   localparam int SIGN_B  = EXP_W + MAN_W;

   typedef enum logic [2:0] {
      FPC_NORMAL  = 3'd0,
      FPC_ZERO    = 3'd1,
      FPC_SUBNORM = 3'd2,
      FPC_INF     = 3'd3,
      FPC_NAN     = 3'd4
   } fp_class_e;

   // Unbiased exponent of a normal FP32 word (field value minus the bias).
   function automatic logic signed [9:0] fp32_unbiased_exp(input logic [EXP_W-1:0] i_exp);
      return $signed({2'b00, i_exp}) - 10'(BIAS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_result_fifo_classify.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : fp32_classify                                                 |
// | Purpose  : Combinational FP32 classifier (exponent/mantissa -> class).   |
// |            The sign bit never affects the class, so it is not an input.  |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module fp32_classify
   import posit_fp_pkg::*;
(
   input  logic [EXP_W+MAN_W-1:0] i_mag,
   output logic [2:0]             o_class
);

   logic [EXP_W-1:0] w_exp;
   logic [MAN_W-1:0] w_man;

   assign w_exp = i_mag[EXP_LSB +: EXP_W];
   assign w_man = i_mag[MAN_LSB +: MAN_W];

   // Decode the reserved exponent values; everything else is a normal number.
   always_comb begin
      o_class = FPC_NORMAL;
      if (w_exp == '0) begin
         o_class = (w_man == '0) ? FPC_ZERO : FPC_SUBNORM;
      end else if (w_exp == '1) begin
         o_class = (w_man == '0) ? FPC_INF : FPC_NAN;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp32_result_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : fp32_result_fifo                                              |
// | Purpose  : First-word-fall-through buffer between the posit-to-FP32      |
// |            converter (no backpressure) and a stalling consumer. Each     |
// |            word is classified on write and stored with its class.        |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module fp32_result_fifo
   import posit_fp_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [2:0]        out_class,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              overflow,
   input  logic              clr_ovf,
   input  logic              flush
);

   localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam int              c_ENTRY_W   = DATA_W + 3;

   logic [c_ENTRY_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0]    r_wr_ptr;
   logic [ADDR_W-1:0]    r_rd_ptr;
   logic [ADDR_W:0]      r_count;
   logic                 r_overflow;

   logic [2:0]           w_class;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_do_pop;
   logic                 w_do_push;
   logic                 w_drop;
   logic [c_ENTRY_W-1:0] w_head;

   fp32_classify u_classify (
      .i_mag   (in_data[EXP_W+MAN_W-1:0]),
      .o_class (w_class)
   );

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_DEPTH_CNT);
   // A pop frees a slot in the same edge, so a full buffer can still take a push.
   assign w_do_pop  = out_ready && !w_empty;
   assign w_do_push = in_valid && (!w_full || w_do_pop);
   assign w_drop    = in_valid && w_full && !w_do_pop && !flush;
   assign w_head    = r_mem[r_rd_ptr];

   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : w_head[DATA_W-1:0];
   assign out_class = w_empty ? '0 : w_head[c_ENTRY_W-1 -: 3];
   assign count     = r_count;
   assign full      = w_full;
   assign overflow  = r_overflow;

   // Storage write; the array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_do_push && !flush) begin
         r_mem[r_wr_ptr] <= {w_class, in_data};
      end
   end

   // Pointers and occupancy; flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp32_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : tb_fp32_result_fifo                                           |
// | Purpose  : Self-checking bench for fp32_result_fifo against a queue      |
// |            reference model.                                              |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module tb_fp32_result_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic [31:0] out_data;
   logic [2:0]  out_class;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  count;
   logic        full;
   logic        overflow;
   logic        clr_ovf;
   logic        flush;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_q[$];
   bit          m_ovf;

   always #5 clk = ~clk;

   fp32_result_fifo #(.DEPTH(8), .ADDR_W(3), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_class(out_class), .out_valid(out_valid),
      .out_ready(out_ready), .count(count), .full(full), .overflow(overflow),
      .clr_ovf(clr_ovf), .flush(flush)
   );

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "timeout");
   end

   function automatic logic [2:0] ref_class(input logic [31:0] w);
      int e = int'((w >> 23) & 32'hFF);
      int m = int'(w & 32'h7FFFFF);
      if (e == 0)   return (m == 0) ? 3'd1 : 3'd2;
      if (e == 255) return (m == 0) ? 3'd3 : 3'd4;
      return 3'd0;
   endfunction

   task automatic drive(input bit v, input logic [31:0] d, input bit rdy, input bit fl, input bit clr);
      in_valid = v; in_data = d; out_ready = rdy; flush = fl; clr_ovf = clr;
   endtask

   // Apply the current inputs at the next rising edge and advance the model.
   task automatic tick();
      bit pop, drop;
      if (flush) begin
         m_q.delete();
         if (clr_ovf) m_ovf = 1'b0;
      end else begin
         pop  = out_ready && (m_q.size() > 0);
         drop = in_valid && (m_q.size() == 8) && !pop;
         if (pop) void'(m_q.pop_front());
         if (in_valid && !drop) m_q.push_back(in_data);
         if (drop) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      drive(0, 32'h0, 0, 0, 0);
      reset = 1'b0;
      m_q.delete(); m_ovf = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got full=%b ovf=%b want 0 0", full, overflow); end
      checks++; if (out_data !== 32'h0 || out_class !== 3'd0) begin errors++; $display("FAIL reset_head got %h/%0d want 0/0", out_data, out_class); end
      #3 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_push();
      drive(1, 32'h3F800000, 0, 0, 0); tick();
      drive(0, 32'h0, 0, 0, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h3F800000 || out_class !== 3'd0 || count !== 4'd1) begin
         errors++; $display("FAIL single_push got v=%b d=%h c=%0d n=%0d want 1 3f800000 0 1", out_valid, out_data, out_class, count);
      end
      drive(0, 32'h0, 1, 0, 0); tick();
      drive(0, 32'h0, 0, 0, 0);
      checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL single_drain got v=%b n=%0d want 0 0", out_valid, count); end
   endtask

   task automatic test_classes();
      logic [31:0] words [4] = '{32'h00000000, 32'h00000001, 32'h7F800000, 32'h7FC00000};
      logic [2:0]  cls   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
      for (int i = 0; i < 4; i++) begin drive(1, words[i], 0, 0, 0); tick(); end
      drive(0, 32'h0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid !== 1'b1 || out_class !== cls[i] || out_data !== words[i] || count !== 4'(4 - i)) begin
            errors++; $display("FAIL classes[%0d] got v=%b d=%h c=%0d n=%0d want 1 %h %0d %0d", i, out_valid, out_data, out_class, count, words[i], cls[i], 4 - i);
         end
         tick();
      end
      drive(0, 32'h0, 0, 0, 0);
      checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL classes_end got v=%b n=%0d want 0 0", out_valid, count); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) begin drive(1, $urandom, 0, 0, 0); tick(); end
      checks++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL fill got full=%b n=%0d ovf=%b want 1 8 0", full, count, overflow); end
      drive(1, 32'h40490FDB, 0, 0, 0); tick();
      drive(0, 32'h0, 0, 0, 0);
      checks++; if (overflow !== 1'b1 || full !== 1'b1 || count !== 4'd8 || out_data !== m_q[0]) begin
         errors++; $display("FAIL drop got ovf=%b full=%b n=%0d head=%h want 1 1 8 %h", overflow, full, count, out_data, m_q[0]);
      end
      drive(0, 32'h0, 0, 0, 1); tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", overflow); end
      drive(1, $urandom, 0, 0, 1); tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b want 1", overflow); end
      drive(0, 32'h0, 0, 0, 1); tick();
      drive(0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_full_pushpop();
      drive(1, 32'h41200000, 1, 0, 0); tick();
      drive(0, 32'h0, 1, 0, 0);
      checks++; if (overflow !== 1'b0 || count !== 4'd8) begin errors++; $display("FAIL full_pushpop got ovf=%b n=%0d want 0 8", overflow, count); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (out_data !== m_q[0]) begin errors++; $display("FAIL full_drain[%0d] got %h want %h", i, out_data, m_q[0]); end
         if (i == 7) begin
            checks++; if (out_data !== 32'h41200000) begin errors++; $display("FAIL last_word got %h want 41200000", out_data); end
         end
         tick();
      end
      drive(0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 9; i++) begin drive(1, $urandom, 0, 0, 0); tick(); end
      for (int i = 0; i < 3; i++) begin drive(0, 32'h0, 1, 0, 0); tick(); end
      checks++; if (count !== 4'd5 || overflow !== 1'b1) begin errors++; $display("FAIL pre_flush got n=%0d ovf=%b want 5 1", count, overflow); end
      drive(1, $urandom, 1, 1, 0); tick();
      drive(0, 32'h0, 0, 0, 0);
      checks++; if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++; $display("FAIL flush got n=%0d v=%b ovf=%b want 0 0 1", count, out_valid, overflow);
      end
      drive(1, 32'hC0000000, 0, 0, 0); tick();
      drive(0, 32'h0, 0, 0, 1);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hC0000000 || count !== 4'd1) begin
         errors++; $display("FAIL post_flush got v=%b d=%h n=%0d want 1 c0000000 1", out_valid, out_data, count);
      end
      tick();
      drive(0, 32'h0, 1, 0, 0); tick();
      drive(0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_async_reset_wrap();
      for (int i = 0; i < 3; i++) begin drive(1, $urandom, 0, 0, 0); tick(); end
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL pre_reset got n=%0d want 3", count); end
      drive(1, $urandom, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL async_reset got v=%b n=%0d want 0 0", out_valid, count); end
      m_q.delete(); m_ovf = 0;
      @(posedge clk); #1;
      drive(0, 32'h0, 0, 0, 0);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL inflight_lost got n=%0d want 0", count); end
      drive(1, $urandom, 0, 0, 0); tick();
      for (int i = 0; i < 20; i++) begin
         drive(1, $urandom, 1, 0, 0);
         checks++; if (out_data !== m_q[0]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, out_data, m_q[0]); end
         tick();
         checks++; if (count !== 4'd1) begin errors++; $display("FAIL wrap_count[%0d] got %0d want 1", i, count); end
      end
      drive(0, 32'h0, 1, 0, 0); tick();
      drive(0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] d, exp_d;
      logic [2:0]  exp_c;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: d = {1'($urandom), 8'h00, (($urandom_range(0, 1) != 0) ? 23'($urandom) : 23'h0)};
            1: d = {1'($urandom), 8'hFF, (($urandom_range(0, 1) != 0) ? 23'($urandom) : 23'h0)};
            default: d = $urandom;
         endcase
         drive($urandom_range(0, 2) != 0, d, $urandom_range(0, 2) == 0,
               $urandom_range(0, 40) == 0, $urandom_range(0, 10) == 0);
         tick();
         exp_d = (m_q.size() > 0) ? m_q[0] : 32'h0;
         exp_c = (m_q.size() > 0) ? ref_class(m_q[0]) : 3'd0;
         checks++;
         if (out_valid !== (m_q.size() > 0) || out_data !== exp_d || out_class !== exp_c ||
             count !== 4'(m_q.size()) || full !== (m_q.size() == 8) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL random[%0d] got v=%b d=%h c=%0d n=%0d f=%b o=%b want v=%b d=%h c=%0d n=%0d f=%b o=%b",
                     i, out_valid, out_data, out_class, count, full, overflow,
                     m_q.size() > 0, exp_d, exp_c, m_q.size(), m_q.size() == 8, m_ovf);
         end
      end
      drive(0, 32'h0, 0, 0, 0);
   endtask

   initial begin
      drive(0, 32'h0, 0, 0, 0);
      reset = 1'b1;
      #1;
      test_reset();
      test_single_push();
      test_classes();
      test_overflow();
      test_full_pushpop();
      test_flush();
      test_async_reset_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
